// File: rtl/motion_sequencer_pkg.sv
// Shared encodings for the motion sequencer: FSM states, remote commands,
// per-motor driver triples {fwd, back, turn} and the command-to-drive map.
package motion_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_DEAD      = 3'd2,
      ST_AVD_BRAKE = 3'd3,
      ST_AVD_BACK  = 3'd4,
      ST_AVD_SPIN  = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CMD_STOP  = 3'd0,
      CMD_FWD   = 3'd1,
      CMD_BACK  = 3'd2,
      CMD_LEFT  = 3'd3,
      CMD_RIGHT = 3'd4
   } cmd_e;

   // Per-motor triple, bit order {fwd, back, turn}
   localparam logic [2:0] M_OFF      = 3'b000;
   localparam logic [2:0] M_FWD      = 3'b100;
   localparam logic [2:0] M_BACK     = 3'b010;
   localparam logic [2:0] M_FWD_TURN = 3'b101;

   typedef struct packed {
      logic [2:0] l;
      logic [2:0] r;
      logic       stop;
   } drive_t;

   localparam drive_t DRIVE_STOP = '{l: M_OFF, r: M_OFF, stop: 1'b1};

   // Raw remote code to command; unused codes 5-7 mean STOP
   function automatic cmd_e decode_cmd(input logic [2:0] raw);
      case (raw)
         3'd1:    decode_cmd = CMD_FWD;
         3'd2:    decode_cmd = CMD_BACK;
         3'd3:    decode_cmd = CMD_LEFT;
         3'd4:    decode_cmd = CMD_RIGHT;
         default: decode_cmd = CMD_STOP;
      endcase
   endfunction

   // Command to motor drive map
   function automatic drive_t cmd_drive(input cmd_e c);
      drive_t d;
      d = DRIVE_STOP;
      case (c)
         CMD_FWD:   begin d.l = M_FWD;      d.r = M_FWD;      d.stop = 1'b0; end
         CMD_BACK:  begin d.l = M_BACK;     d.r = M_BACK;     d.stop = 1'b0; end
         CMD_LEFT:  begin d.l = M_FWD_TURN; d.r = M_FWD;      d.stop = 1'b0; end
         CMD_RIGHT: begin d.l = M_FWD;      d.r = M_FWD_TURN; d.stop = 1'b0; end
         default:   d = DRIVE_STOP;
      endcase
      return d;
   endfunction

   // True when either motor would flip between forward and back
   function automatic logic reverses(input drive_t a, input drive_t b);
      return (a.l[2] & b.l[1]) | (a.l[1] & b.l[2]) |
             (a.r[2] & b.r[1]) | (a.r[1] & b.r[2]);
   endfunction

endpackage

// File: rtl/motion_sequencer_sync2.sv
// Two-flop level synchroniser for the asynchronous obstacle sensor.
module motion_sequencer_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic d_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next-value logic: shift the sensor level through two stages
   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   // Synchroniser flops, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q;

endmodule

// File: rtl/motion_sequencer.sv
// Motion sequencer: priority e-stop > obstacle avoidance > remote, with a
// stopped dead-time before any reversal and a fixed back-off-and-spin run.
// Remote handshake: cmd is taken on every clk edge where cmd_valid is high;
// there is no ready, commands arriving in AVD_* states or under estop are
// simply dropped. The state port exposes the FSM for LEDs and checkers.
module motion_sequencer
   import motion_sequencer_pkg::*;
#(
   parameter int CW       = 16,
   parameter int DEAD_CYC = 16,
   parameter int BACK_CYC = 2000,
   parameter int SPIN_CYC = 1500,
   parameter int TIMEOUT  = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] cmd,
   input  logic       cmd_valid,
   input  logic       obstacle,
   input  logic       estop,
   output logic       l_fwd,
   output logic       l_back,
   output logic       l_turn,
   output logic       r_fwd,
   output logic       r_back,
   output logic       r_turn,
   output logic       stop,
   output logic       busy,
   output logic [2:0] state
);

   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
   localparam logic [CW-1:0] BACK_LAST = CW'(BACK_CYC - 1);
   localparam logic [CW-1:0] SPIN_LAST = CW'(SPIN_CYC - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

   state_e         state_q, state_d;
   cmd_e           held_q, held_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   drive_t         drv_q, drv_d;
   logic           busy_q, busy_d;

   logic           obs_s;
   cmd_e           cmd_n;
   drive_t         new_drv, held_drv;
   logic           cnt_clr;

   motion_sequencer_sync2 u_obs_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (obstacle),
      .d_out (obs_s)
   );

   // Next state, held/pending command, counter and registered-output decode
   always_comb begin
      state_d  = state_q;
      held_d   = held_q;
      cnt_clr  = 1'b0;
      cmd_n    = decode_cmd(cmd);
      new_drv  = cmd_drive(cmd_n);
      held_drv = cmd_drive(held_q);

      if (estop) begin
         state_d = ST_IDLE;
         held_d  = CMD_STOP;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Starting from rest always goes through the dead-time
               if (cmd_valid && cmd_n != CMD_STOP) begin
                  state_d = ST_DEAD;
                  held_d  = cmd_n;
               end
            end
            ST_RUN: begin
               if (obs_s && (held_q == CMD_FWD || held_q == CMD_LEFT ||
                             held_q == CMD_RIGHT)) begin
                  state_d = ST_AVD_BRAKE;
                  held_d  = CMD_STOP;
               end else if (cmd_valid) begin
                  if (cmd_n == CMD_STOP) begin
                     state_d = ST_IDLE;
                     held_d  = CMD_STOP;
                  end else if (reverses(held_drv, new_drv)) begin
                     state_d = ST_DEAD;
                     held_d  = cmd_n;
                  end else begin
                     held_d  = cmd_n;
                     cnt_clr = 1'b1;
                  end
               end else if (cnt_q == TO_LAST) begin
                  state_d = ST_IDLE;
                  held_d  = CMD_STOP;
               end
            end
            ST_DEAD: begin
               // A new command replaces the pending one without restarting the count
               if (cmd_valid && cmd_n == CMD_STOP) begin
                  state_d = ST_IDLE;
                  held_d  = CMD_STOP;
               end else begin
                  if (cmd_valid) held_d = cmd_n;
                  if (cnt_q == DEAD_LAST) state_d = ST_RUN;
               end
            end
            ST_AVD_BRAKE: if (cnt_q == DEAD_LAST) state_d = ST_AVD_BACK;
            ST_AVD_BACK:  if (cnt_q == BACK_LAST) state_d = ST_AVD_SPIN;
            ST_AVD_SPIN: begin
               if (cnt_q == SPIN_LAST) begin
                  state_d = ST_IDLE;
                  held_d  = CMD_STOP;
               end
            end
            default: begin
               state_d = ST_IDLE;
               held_d  = CMD_STOP;
            end
         endcase
      end

      // Shared counter restarts on any state change; IDLE keeps it parked at 0
      if (state_d != state_q || cnt_clr || state_q == ST_IDLE)
         cnt_d = '0;
      else
         cnt_d = cnt_q + CW'(1);

      // Outputs are decoded from the next state so they line up with state_q
      case (state_d)
         ST_RUN:      drv_d = cmd_drive(held_d);
         ST_AVD_BACK: drv_d = cmd_drive(CMD_BACK);
         ST_AVD_SPIN: drv_d = '{l: M_FWD, r: M_BACK, stop: 1'b0};
         default:     drv_d = DRIVE_STOP;
      endcase
      busy_d = (state_d == ST_AVD_BRAKE) || (state_d == ST_AVD_BACK) ||
               (state_d == ST_AVD_SPIN);
   end

   // State, command, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         held_q  <= CMD_STOP;
         cnt_q   <= '0;
         drv_q   <= DRIVE_STOP;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         cnt_q   <= cnt_d;
         drv_q   <= drv_d;
         busy_q  <= busy_d;
      end
   end

   assign l_fwd  = drv_q.l[2];
   assign l_back = drv_q.l[1];
   assign l_turn = drv_q.l[0];
   assign r_fwd  = drv_q.r[2];
   assign r_back = drv_q.r[1];
   assign r_turn = drv_q.r[0];
   assign stop   = drv_q.stop;
   assign busy   = busy_q;
   assign state  = state_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: the driver pushes the expected output
// vector for each upcoming cycle into exp_q, tagged with the cycle number;
// the monitor pops and compares on the falling edge.
module tb_motion_sequencer;

   // Expected vector {state[2:0], busy, stop, l_fwd,l_back,l_turn, r_fwd,r_back,r_turn}
   localparam logic [10:0] V_IDLE  = {3'd0, 1'b0, 1'b1, 6'b000_000};
   localparam logic [10:0] V_DEAD  = {3'd2, 1'b0, 1'b1, 6'b000_000};
   localparam logic [10:0] V_FWD   = {3'd1, 1'b0, 1'b0, 6'b100_100};
   localparam logic [10:0] V_BACKR = {3'd1, 1'b0, 1'b0, 6'b010_010};
   localparam logic [10:0] V_LEFT  = {3'd1, 1'b0, 1'b0, 6'b101_100};
   localparam logic [10:0] V_RIGHT = {3'd1, 1'b0, 1'b0, 6'b100_101};
   localparam logic [10:0] V_BRAKE = {3'd3, 1'b1, 1'b1, 6'b000_000};
   localparam logic [10:0] V_AVBK  = {3'd4, 1'b1, 1'b0, 6'b010_010};
   localparam logic [10:0] V_SPIN  = {3'd5, 1'b1, 1'b0, 6'b100_010};

   logic       clk;
   logic       rst_n;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       obstacle;
   logic       estop;
   logic       l_fwd, l_back, l_turn, r_fwd, r_back, r_turn;
   logic       stop, busy;
   logic [2:0] state;

   logic [42:0] exp_q[$];
   logic [42:0] mon_ent;
   logic [10:0] act;
   logic [31:0] cyc_cnt;
   int          n_checks;
   int          n_errors;
   string       phase;

   motion_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .obstacle  (obstacle),
      .estop     (estop),
      .l_fwd     (l_fwd),
      .l_back    (l_back),
      .l_turn    (l_turn),
      .r_fwd     (r_fwd),
      .r_back    (r_back),
      .r_turn    (r_turn),
      .stop      (stop),
      .busy      (busy),
      .state     (state)
   );

   assign act = {state, busy, stop, l_fwd, l_back, l_turn, r_fwd, r_back, r_turn};

   // Clock and cycle index
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc_cnt = '0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

   // Report helper shared by the monitor and the asynchronous-reset check
   task automatic report(input string name, input logic [31:0] c,
                         input logic [10:0] got, input logic [10:0] want);
      $display("FAIL %s @cyc %0d: got state=%0d busy=%b stop=%b l=%03b r=%03b, expected state=%0d busy=%b stop=%b l=%03b r=%03b",
               name, c, got[10:8], got[7], got[6], got[5:3], got[2:0],
               want[10:8], want[7], want[6], want[5:3], want[2:0]);
   endtask

   // Monitor: compare every expectation due for this cycle
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0][42:11] <= cyc_cnt) begin
         mon_ent = exp_q.pop_front();
         n_checks++;
         if (mon_ent[42:11] != cyc_cnt || act !== mon_ent[10:0]) begin
            n_errors++;
            report(phase, mon_ent[42:11], act, mon_ent[10:0]);
         end
      end
   end

   // Driver tasks: inputs set before a call apply at the next rising edge
   task automatic cyc(input logic [10:0] e);
      exp_q.push_back({cyc_cnt + 32'd1, e});
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic [10:0] e);
      for (int i = 0; i < n; i++) cyc(e);
   endtask

   task automatic send(input logic [2:0] c);
      cmd       = c;
      cmd_valid = 1'b1;
   endtask

   task automatic go_fwd_from_idle();
      send(3'd1);
      cyc(V_DEAD);
      cmd_valid = 1'b0;
      run(15, V_DEAD);
      cyc(V_FWD);
   endtask

   initial begin
      rst_n = 1'b0; cmd = 3'd0; cmd_valid = 1'b0; obstacle = 1'b0; estop = 1'b0;
      n_checks = 0; n_errors = 0;
      phase = "reset";
      @(negedge clk);
      run(2, V_IDLE);
      rst_n = 1'b1;
      run(2, V_IDLE);

      // 1: start from rest goes through 16 stopped cycles; pending replaced mid-DEAD
      phase = "t1_start";
      send(3'd1);
      cyc(V_DEAD);
      cmd_valid = 1'b0;
      run(4, V_DEAD);
      send(3'd4);
      cyc(V_DEAD);
      cmd_valid = 1'b0;
      run(10, V_DEAD);
      cyc(V_RIGHT);
      run(2, V_RIGHT);

      // 2: non-reversing changes are immediate; reversal inserts dead-time
      phase = "t2_change";
      send(3'd1);
      cyc(V_FWD);
      cmd_valid = 1'b0;
      run(2, V_FWD);
      send(3'd3);
      cyc(V_LEFT);
      cmd_valid = 1'b0;
      run(2, V_LEFT);
      phase = "t2_reverse";
      send(3'd2);
      cyc(V_DEAD);
      cmd_valid = 1'b0;
      run(15, V_DEAD);
      cyc(V_BACKR);
      run(2, V_BACKR);
      phase = "t2_code7_stop";
      send(3'd7);
      cyc(V_IDLE);
      cmd_valid = 1'b0;
      run(2, V_IDLE);

      // 3: obstacle while forward runs the full avoidance sequence
      phase = "t3_avoid";
      go_fwd_from_idle();
      obstacle = 1'b1;
      cyc(V_FWD);
      cyc(V_FWD);
      cyc(V_BRAKE);
      send(3'd1);
      run(15, V_BRAKE);
      run(100, V_AVBK);
      cmd_valid = 1'b0;
      run(1900, V_AVBK);
      obstacle = 1'b0;
      run(1500, V_SPIN);
      cyc(V_IDLE);
      run(2, V_IDLE);

      // 4: obstacle ignored while reversing; timeout after 50000 idle-remote cycles
      phase = "t4_timeout";
      send(3'd2);
      cyc(V_DEAD);
      cmd_valid = 1'b0;
      run(15, V_DEAD);
      cyc(V_BACKR);
      obstacle = 1'b1;
      run(49999, V_BACKR);
      cyc(V_IDLE);
      obstacle = 1'b0;
      run(3, V_IDLE);

      // 5: estop aborts avoidance and holds IDLE while high
      phase = "t5_estop";
      go_fwd_from_idle();
      obstacle = 1'b1;
      cyc(V_FWD);
      cyc(V_FWD);
      cyc(V_BRAKE);
      run(15, V_BRAKE);
      run(10, V_AVBK);
      estop = 1'b1;
      obstacle = 1'b0;
      cyc(V_IDLE);
      send(3'd1);
      run(5, V_IDLE);
      estop = 1'b0;
      cyc(V_DEAD);
      cmd_valid = 1'b0;
      run(15, V_DEAD);
      cyc(V_FWD);

      // 6: asynchronous reset mid-DEAD, then obstacle beats same-cycle command
      phase = "t6_reset";
      send(3'd2);
      cyc(V_DEAD);
      cmd_valid = 1'b0;
      run(5, V_DEAD);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (act !== V_IDLE) begin
         n_errors++;
         report("t6_async_reset", cyc_cnt, act, V_IDLE);
      end
      cyc(V_IDLE);
      rst_n = 1'b1;
      cyc(V_IDLE);
      phase = "t6_obstacle_wins";
      go_fwd_from_idle();
      obstacle = 1'b1;
      cyc(V_FWD);
      cyc(V_FWD);
      send(3'd3);
      cyc(V_BRAKE);
      cmd_valid = 1'b0;
      obstacle = 1'b0;
      run(15, V_BRAKE);
      cyc(V_AVBK);
      estop = 1'b1;
      cyc(V_IDLE);
      estop = 1'b0;
      run(2, V_IDLE);

      // Drain: every pushed expectation must have been compared
      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
